// File: rtl/branch_resolver_if.sv
// rtl/branch_resolver_if.sv - request/response bundle between ALU flags, branch resolver and PC-update logic
interface branch_resolver_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_SIZE  = 4
);
    logic                  start_i;
    logic [FLAG_SIZE-1:0]  flags_i;
    logic [2:0]            funct3_i;
    logic [DATA_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] imm_i;
    logic                  ready_i;
    logic                  valid_o;
    logic                  taken_o;
    logic [DATA_WIDTH-1:0] next_pc_o;
    logic                  illegal_o;
    logic                  misalign_o;
    logic                  busy_o;

    modport master (
        output start_i, flags_i, funct3_i, pc_i, imm_i, ready_i,
        input  valid_o, taken_o, next_pc_o, illegal_o, misalign_o, busy_o
    );

    modport slave (
        input  start_i, flags_i, funct3_i, pc_i, imm_i, ready_i,
        output valid_o, taken_o, next_pc_o, illegal_o, misalign_o, busy_o
    );
endinterface

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - resolves a conditional branch from SubOp flags and presents the next PC
module branch_resolver #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_SIZE  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    branch_resolver_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EVAL, PRESENT} state_t;

    state_t state, state_d;
    logic   load, eval, clear;

    logic [FLAG_SIZE-1:0]  flags_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] imm_q;

    logic                  valid_q;
    logic                  taken_q;
    logic [DATA_WIDTH-1:0] next_pc_q;
    logic                  illegal_q;
    logic                  misalign_q;

    logic                  cond;
    logic                  bad_funct3;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] seq_pc;

    // Flag layout is {V,N,C,Z}; C is the borrow, so it means rs1 < rs2 unsigned.
    wire flag_v = flags_q[3];
    wire flag_n = flags_q[2];
    wire flag_c = flags_q[1];
    wire flag_z = flags_q[0];

    // Target keeps bit 0 cleared; bit 1 is left intact so misalignment can be reported.
    assign target = (pc_q + imm_q) & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign seq_pc = pc_q + DATA_WIDTH'(4);

    // Branch condition decode; the two unused funct3 codes resolve as not-taken and flag illegal.
    always_comb begin
        cond       = 1'b0;
        bad_funct3 = 1'b0;
        case (funct3_q)
            3'b000:  cond = flag_z;
            3'b001:  cond = !flag_z;
            3'b100:  cond = flag_n ^ flag_v;
            3'b101:  cond = !(flag_n ^ flag_v);
            3'b110:  cond = flag_c;
            3'b111:  cond = !flag_c;
            default: bad_funct3 = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_d;
    end

    // Next-state and control strobes; start is only honoured from IDLE, so no queueing.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        eval    = 1'b0;
        clear   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                eval    = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (bus.ready_i) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture at start, result registration in EVAL, result clear on handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            flags_q    <= '0;
            funct3_q   <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
            next_pc_q  <= '0;
            illegal_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (load) begin
                flags_q  <= bus.flags_i;
                funct3_q <= bus.funct3_i;
                pc_q     <= bus.pc_i;
                imm_q    <= bus.imm_i;
            end
            if (eval) begin
                valid_q    <= 1'b1;
                taken_q    <= cond;
                next_pc_q  <= cond ? target : seq_pc;
                illegal_q  <= bad_funct3;
                misalign_q <= cond & target[1];
            end
            if (clear) begin
                valid_q    <= 1'b0;
                taken_q    <= 1'b0;
                next_pc_q  <= '0;
                illegal_q  <= 1'b0;
                misalign_q <= 1'b0;
            end
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.taken_o    = taken_q;
    assign bus.next_pc_o  = next_pc_q;
    assign bus.illegal_o  = illegal_q;
    assign bus.misalign_o = misalign_q;
    assign bus.busy_o     = (state != IDLE);
endmodule
